pulse_stretch: RTL
==================

Name: pulse_stretch

Overview:
- Turns single-cycle trigger pulses into a registered level pulse of a run-time programmable length. It is the inverse of our rising-edge detectors.
- Used wherever a one-clock strobe must drive a slower consumer, for example LEDs, cross-domain handshakes or external gate lines.
- Supports a retrigger mode and a post-pulse holdoff. Triggers that are ignored are counted.

Parameters:
CNT_BITS, 8, width of LEN and of the internal length counter
RETRIGGER, 0, 1 = a trigger while active reloads the length counter; 0 = the trigger is ignored and counted as dropped
HOLDOFF, 0, minimum number of O-low cycles forced after each pulse (0 = none, legal range 0..2^CNT_BITS-1)
DROP_BITS, 8, width of the dropped-trigger counter

Ports:
CLK  input  1  clock; all logic on the rising edge
RST_N  input  1  asynchronous active-low reset
I  input  1  trigger; sampled high on a CLK edge = trigger request
LEN  input  CNT_BITS  pulse length in cycles; sampled at trigger/reload; 0 treated as 1
DROP_CLR  input  1  synchronous clear of DROP_CNT
O  output  1  stretched pulse, registered
BUSY  output  1  high when the state is not IDLE, registered
DROP_CNT  output  DROP_BITS  saturating count of ignored triggers

Behaviour:
- Reset (RST_N low, asynchronous, valid at any time including mid-pulse): state=IDLE, O=0, BUSY=0, cnt=0, hcnt=0, DROP_CNT=0. The first trigger is honoured on the first CLK edge after RST_N deasserts.
- L = (LEN==0) ? 1 : LEN, evaluated in the same cycle the trigger is sampled.
- Latency: I sampled high at edge k in IDLE -> O high after edge k and remaining high for exactly L cycles.
- FSM states: IDLE, ACTIVE, HOLD.
- IDLE: O=0.
  - I=1 -> cnt=L-1, O=1, go to ACTIVE.
- ACTIVE: O=1.
  - RETRIGGER=1 and I=1 -> cnt=L-1 with the current LEN; stay in ACTIVE. The pulse is extended, never shortened below the new L.
  - Else if cnt!=0 -> cnt=cnt-1. With RETRIGGER=0, an I=1 in this case counts as a drop.
  - Else (cnt==0, last high cycle):
    - HOLDOFF==0 and I=1 -> treated as a new trigger: cnt=L-1, stay in ACTIVE. O stays high continuously; not a drop.
    - HOLDOFF>0 -> O=0, hcnt=HOLDOFF-1, go to HOLD. An I=1 here counts as a drop.
    - Otherwise -> O=0, go to IDLE.
- HOLD: O=0.
  - Every I=1, including in the final HOLD cycle, counts as a drop.
  - hcnt!=0 -> hcnt=hcnt-1.
  - hcnt==0 -> go to IDLE.
  - Result: at least HOLDOFF O-low cycles between pulses.
- BUSY: 1 in ACTIVE and HOLD, 0 in IDLE; registered together with the state.
- DROP_CNT:
  - +1 per drop event, saturating at all-ones; no wrap.
  - DROP_CLR=1 with no drop -> 0.
  - DROP_CLR=1 and a drop in the same cycle -> 1.
- LEN changes while in ACTIVE have no effect until the next load or reload.
- No combinational path from any input to any output.

Test Plan:
- Reset, LEN=4, RETRIGGER=0, HOLDOFF=0; I pulse at edge 10 -> O=1 for cycles 11..14, O=0 at 15; BUSY same as O; DROP_CNT=0.
- LEN=0; single I pulse -> O high for exactly 1 cycle. Then I held high for 3 cycles -> O high for 3 contiguous cycles; DROP_CNT=0.
- RETRIGGER=0, LEN=5; I at edges 0 and 2 -> O high for cycles 1..5 only, DROP_CNT=1. Repeat with RETRIGGER=1 -> O high for cycles 1..7, DROP_CNT=0.
- HOLDOFF=3, LEN=2; I at edge 0, then I held high for edges 3..6 -> O high for cycles 1..2, low for 3..5. Re-trigger at edge 6 -> O high for cycles 7..8. DROP_CNT=3 (edges 3,4,5).
- Saturation/clear, DROP_BITS=2: 5 drops -> DROP_CNT=3. DROP_CLR together with a drop -> 1. DROP_CLR alone -> 0.
- Mid-pulse reset, LEN=200: assert RST_N low asynchronously (between edges) at cycle 50 -> O, BUSY and DROP_CNT go to 0 immediately. After release, an I pulse gives a fresh 200-cycle pulse.

Source files
------------

// File: rtl/pulse_stretch.sv
// pulse_stretch: turns single-cycle trigger strobes into a registered level
// pulse whose length is taken from LEN when the trigger is accepted. It has an
// optional retrigger mode, an optional post-pulse holdoff, and a saturating
// count of ignored triggers.
module pulse_stretch #(
  parameter int CNT_BITS  = 8,
  parameter bit RETRIGGER = 1'b0,
  parameter int HOLDOFF   = 0,
  parameter int DROP_BITS = 8
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 I,
  input  logic [CNT_BITS-1:0]  LEN,
  input  logic                 DROP_CLR,
  output logic                 O,
  output logic                 BUSY,
  output logic [DROP_BITS-1:0] DROP_CNT
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;

  // Holdoff counter load value; the counter runs HOLDOFF-1 down to 0, so the
  // FSM spends exactly HOLDOFF cycles in HOLD.
  localparam int                HOLD_M1   = (HOLDOFF > 0) ? HOLDOFF - 1 : 0;
  localparam logic [CNT_BITS-1:0] HOLD_LOAD = CNT_BITS'(HOLD_M1);

  logic [1:0]          state;
  logic [1:0]          state_next;
  logic [CNT_BITS-1:0] cnt;
  logic [CNT_BITS-1:0] cnt_next;
  logic [CNT_BITS-1:0] hcnt;
  logic [CNT_BITS-1:0] hcnt_next;
  logic [CNT_BITS-1:0] len_m1;
  logic                drop;

  // A length of zero is treated as one cycle, so the load value never underflows.
  assign len_m1 = (LEN == '0) ? '0 : LEN - CNT_BITS'(1);

  // Next-state, counter reload and drop-event decode for the stretcher FSM.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    hcnt_next  = hcnt;
    drop       = 1'b0;
    case (state)
      IDLE: begin
        if (I) begin
          cnt_next   = len_m1;
          state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        if (RETRIGGER && I) begin
          cnt_next = len_m1;
        end else if (cnt != '0) begin
          cnt_next = cnt - CNT_BITS'(1);
          drop     = I;
        end else if ((HOLDOFF == 0) && I) begin
          cnt_next = len_m1;
        end else if (HOLDOFF > 0) begin
          hcnt_next  = HOLD_LOAD;
          state_next = HOLD;
          drop       = I;
        end else begin
          state_next = IDLE;
        end
      end
      HOLD: begin
        drop = I;
        if (hcnt != '0) begin
          hcnt_next = hcnt - CNT_BITS'(1);
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, counters and the registered O/BUSY outputs, all derived from the next state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      cnt   <= '0;
      hcnt  <= '0;
      O     <= 1'b0;
      BUSY  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      hcnt  <= hcnt_next;
      O     <= (state_next == ACTIVE);
      BUSY  <= (state_next != IDLE);
    end
  end

  // Saturating dropped-trigger counter; a clear in the same cycle as a drop leaves one.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      DROP_CNT <= '0;
    end else if (DROP_CLR) begin
      DROP_CNT <= drop ? DROP_BITS'(1) : '0;
    end else if (drop && (DROP_CNT != '1)) begin
      DROP_CNT <= DROP_CNT + DROP_BITS'(1);
    end
  end

endmodule
